// File: rtl/tvbg_pkg.sv
// Shared types and default constants for the TV-B-Gone session scheduler.
package tvbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        RUN,
        GAP_ARM,
        GAP_WAIT,
        FAULT
    } sched_state_e;

    localparam int          DEFAULT_DEBOUNCE_CYCLES = 65536;
    localparam logic [15:0] DEFAULT_GAP_TICKS       = 16'd5000;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle pulse on the
// debounced rising edge of the button.
module button_debouncer
    import tvbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic press
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] count;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= sync_b;
                press <= sync_b;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/session_scheduler.sv
// Top-level TV-B-Gone sequencer: starts/supervises controller sessions, inserts
// loop-mode gaps and arbitrates the shared delay unit.
module session_scheduler
    import tvbg_pkg::*;
#(
    parameter int                    DELAY_BITS      = 16,
    parameter int                    DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [DELAY_BITS-1:0] GAP_TICKS       = DELAY_BITS'(DEFAULT_GAP_TICKS),
    parameter int                    START_TIMEOUT   = 8,
    parameter int                    BLINK_CYCLES    = 2**20,
    parameter int                    SESSION_BITS    = 8
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    input  logic                    button_in,
    input  logic                    loop_mode_in,
    output logic                    ctrl_start_out,
    output logic                    ctrl_reset_out,
    input  logic                    ctrl_busy_in,
    input  logic                    ctrl_fail_in,
    input  logic                    ctrl_delay_enable_in,
    input  logic                    ctrl_delay_start_strobe_in,
    input  logic [DELAY_BITS-1:0]   ctrl_delay_value_in,
    output logic                    ctrl_delay_busy_out,
    output logic                    delay_enable_out,
    output logic                    delay_start_strobe_out,
    output logic [DELAY_BITS-1:0]   delay_value_out,
    input  logic                    delay_busy_in,
    output logic                    led_out,
    output logic [SESSION_BITS-1:0] session_count_out
);

    localparam int            TW      = $clog2(START_TIMEOUT + 1);
    localparam int            BW      = $clog2(BLINK_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

    sched_state_e  state;
    logic          press;
    logic          owns_delay;
    logic [TW-1:0] timeout_count;
    logic [BW-1:0] blink_count;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock  (clock_in),
        .reset_n(reset_n_in),
        .button (button_in),
        .press  (press)
    );

    // The controller is idle during the gap, so a plain mux cannot contend.
    assign owns_delay             = (state == GAP_ARM) || (state == GAP_WAIT);
    assign delay_enable_out       = owns_delay ? 1'b1 : ctrl_delay_enable_in;
    assign delay_start_strobe_out = owns_delay ? (state == GAP_ARM) : ctrl_delay_start_strobe_in;
    assign delay_value_out        = owns_delay ? GAP_TICKS : ctrl_delay_value_in;
    assign ctrl_delay_busy_out    = owns_delay ? 1'b0 : delay_busy_in;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state             <= IDLE;
            ctrl_start_out    <= 1'b0;
            ctrl_reset_out    <= 1'b0;
            led_out           <= 1'b0;
            session_count_out <= '0;
            timeout_count     <= '0;
            blink_count       <= '0;
        end else begin
            ctrl_start_out <= 1'b0;
            ctrl_reset_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        ctrl_start_out <= 1'b1;
                        timeout_count  <= '0;
                        led_out        <= 1'b1;
                        state          <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (ctrl_busy_in) begin
                        state <= RUN;
                    end else if (timeout_count == TO_LAST) begin
                        blink_count <= '0;
                        state       <= FAULT;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                RUN: begin
                    // Fail outranks both an abort press and a normal busy fall.
                    if (ctrl_fail_in) begin
                        ctrl_reset_out <= 1'b1;
                        blink_count    <= '0;
                        state          <= FAULT;
                    end else if (press) begin
                        ctrl_reset_out <= 1'b1;
                        led_out        <= 1'b0;
                        state          <= IDLE;
                    end else if (!ctrl_busy_in) begin
                        session_count_out <= session_count_out + 1'b1;
                        if (loop_mode_in) begin
                            state <= GAP_ARM;
                        end else begin
                            led_out <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                GAP_ARM: begin
                    if (press) begin
                        led_out <= 1'b0;
                        state   <= IDLE;
                    end else if (delay_busy_in) begin
                        state <= GAP_WAIT;
                    end
                end
                GAP_WAIT: begin
                    if (press) begin
                        led_out <= 1'b0;
                        state   <= IDLE;
                    end else if (!delay_busy_in) begin
                        if (loop_mode_in) begin
                            ctrl_start_out <= 1'b1;
                            timeout_count  <= '0;
                            state          <= WAIT_BUSY;
                        end else begin
                            led_out <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                FAULT: begin
                    if (press) begin
                        led_out <= 1'b0;
                        state   <= IDLE;
                    end else if (blink_count == BL_LAST) begin
                        led_out     <= ~led_out;
                        blink_count <= '0;
                    end else begin
                        blink_count <= blink_count + 1'b1;
                    end
                end
                default: begin
                    led_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/session_scheduler.md
# session_scheduler

Top-level sequencer for the TV-B-Gone transmit path; sits between the user button and the code-playback controller. It debounces the button and starts one pass through the code database. It supervises the controller's busy/fail outputs and aborts on a second press. In loop mode it inserts an inter-session gap using the single shared delay unit, which it arbitrates between itself and the controller.

## Interface
- `DELAY_BITS`, 16: delay unit value width.
- `DEBOUNCE_CYCLES`, 65536: clocks the button must be stable before a level change is accepted; ≥2.
- `GAP_TICKS`, 16'd5000: delay value loaded for the inter-session gap; nonzero.
- `START_TIMEOUT`, 8: clocks allowed for controller busy to rise after start.
- `BLINK_CYCLES`, 2**20: LED half-period in FAULT.
- `SESSION_BITS`, 8: session counter width.

- `clock_in` in 1: single clock.
- `reset_n_in` in 1: asynchronous, active-low reset.
- `button_in` in 1: raw push button, active high, asynchronous to the clock.
- `loop_mode_in` in 1: when high, restart after each completed session.
- `ctrl_start_out` out 1: one-cycle start pulse to the controller.
- `ctrl_reset_out` out 1: one-cycle synchronous abort pulse to the controller.
- `ctrl_busy_in` in 1: controller busy.
- `ctrl_fail_in` in 1: controller fail.
- `ctrl_delay_enable_in` in 1: controller delay request, enable.
- `ctrl_delay_start_strobe_in` in 1: controller delay request, start strobe.
- `ctrl_delay_value_in` in DELAY_BITS: controller delay request, value.
- `ctrl_delay_busy_out` out 1: delay busy returned to the controller.
- `delay_enable_out` out 1: to the shared delay unit.
- `delay_start_strobe_out` out 1: to the shared delay unit.
- `delay_value_out` out DELAY_BITS: to the shared delay unit.
- `delay_busy_in` in 1: from the shared delay unit.
- `led_out` out 1: status LED.
- `session_count_out` out SESSION_BITS: completed sessions; wraps modulo 2^SESSION_BITS.

## Operation
- **Button path:** 2-flop synchronizer, then a stability counter. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal samples. `press` is a one-cycle pulse on the debounced rising edge.
- **States:**
  - **IDLE:** on `press`, pulse `ctrl_start_out` and go to WAIT_BUSY.
  - **WAIT_BUSY:** when `ctrl_busy_in` is high, go to RUN. If `START_TIMEOUT` clocks pass first, go to FAULT.
  - **RUN:**
    - If `ctrl_fail_in` is high, pulse `ctrl_reset_out` and go to FAULT. Fail has priority over press and over a busy fall in the same cycle.
    - Otherwise, on `press`, pulse `ctrl_reset_out` and go to IDLE (abort; no count).
    - Otherwise, on `ctrl_busy_in` low, increment `session_count_out`. Go to GAP_ARM if `loop_mode_in`, else IDLE.
  - **GAP_ARM:** scheduler owns the delay unit. Drive `delay_start_strobe_out`=1 and `delay_value_out`=`GAP_TICKS`. Go to GAP_WAIT on the first cycle `delay_busy_in` is high.
  - **GAP_WAIT:** strobe is 0. When `delay_busy_in` falls:
    - if `loop_mode_in` is still high, pulse `ctrl_start_out` and go to WAIT_BUSY;
    - otherwise go to IDLE.
    - A `press` in GAP_ARM or GAP_WAIT goes to IDLE immediately.
  - **FAULT:** `led_out` toggles every `BLINK_CYCLES`. On `press`, go to IDLE.
- **Delay arbitration:**
  - In GAP_ARM and GAP_WAIT the scheduler owns the delay unit: `delay_enable_out`=1, `ctrl_delay_busy_out`=0.
  - In all other states the controller's signals pass through combinationally and `ctrl_delay_busy_out`=`delay_busy_in`.
  - The controller is idle whenever the scheduler owns the unit, so no contention can occur.
- **LED:** 0 in IDLE; 1 in WAIT_BUSY, RUN and GAP_*; blinking in FAULT.

## Timing
- Asynchronous reset values:
  - state IDLE; all counters 0; debounced level 0.
  - `ctrl_start_out`, `ctrl_reset_out`, `led_out` = 0; `session_count_out` = 0.
  - delay outputs in controller pass-through.
- Press latency: `press` is asserted `DEBOUNCE_CYCLES`+2 clocks after a stable button rise. `ctrl_start_out` is high the following clock, for exactly one cycle.
- `ctrl_start_out` and `ctrl_reset_out` are registered and never high in the same cycle.
- A counter increment on a busy fall is visible on `session_count_out` the next clock.
- The gap strobe is held until the delay unit acknowledges with busy high. `delay_value_out` is stable while the strobe is high.
- Reset asserted mid-session: the scheduler returns to IDLE asynchronously. Cleanup of the controller is the responsibility of its own reset.

## Structure
- Package `tvbg_pkg`: `sched_state_e` enum (IDLE, WAIT_BUSY, RUN, GAP_ARM, GAP_WAIT, FAULT) and default constants for `GAP_TICKS` and `DEBOUNCE_CYCLES`.
- Sub-module `button_debouncer` (synchronizer, stability counter, rising-edge pulse), parameterised by `DEBOUNCE_CYCLES`.
- FSM, timeout counter, blink counter, session counter and delay mux live in `session_scheduler`.

## Test plan
Parameters: `DEBOUNCE_CYCLES`=4, `START_TIMEOUT`=8, `GAP_TICKS`=16, `BLINK_CYCLES`=4.
- **Bounce rejection:** button glitches high for 3 clocks → no `ctrl_start_out`. Stable high for 4 clocks → exactly one start pulse, 7 clocks after the rise.
- **Single session:** `loop_mode_in`=0; busy rises 1 clock after start and falls 100 clocks later → `session_count_out` 0→1, state IDLE, LED 1→0, no delay strobe from the scheduler.
- **Loop with gap:** `loop_mode_in`=1; session ends → `delay_value_out`=16 with strobe held until `delay_busy_in`. After busy falls, a new start pulse follows. `ctrl_delay_busy_out`=0 throughout the gap. After 3 sessions, the count is 3.
- **Fail:** `ctrl_fail_in` and busy fall arrive in the same RUN cycle → one `ctrl_reset_out` pulse, FAULT, LED toggling every 4 clocks, count unchanged. A press returns to IDLE.
- **Start timeout and abort:** busy never rises → FAULT after 8 clocks. Separately, a press during RUN → `ctrl_reset_out` pulse, IDLE, count unchanged.
- **Async reset mid-gap:** `reset_n_in` low → all outputs return to reset values without a clock edge.
